// File: rtl/mips_dmem.sv
// MIPS data memory: CPU byte-lane port with one-cycle registered reads, plus a
// host preload/inspect port that only gets cycles the CPU leaves idle.
module mips_dmem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_read_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    output logic        addr_err
);

    localparam logic [31:0] BYTES = 32'(DEPTH_WORDS) << 2;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          cpu_busy;
    logic          cpu_wr;
    logic          cpu_rd;
    logic          cpu_ok;
    logic          host_acc;
    logic          host_ok;
    logic [AW-1:0] cpu_idx;
    logic [AW-1:0] host_idx;

    // A write wins over a simultaneous (illegal) read request.
    always_comb begin
        cpu_busy = en & (mem_read_en | (|mem_write_en));
        cpu_wr   = en & (|mem_write_en);
        cpu_rd   = en & mem_read_en & ~(|mem_write_en);
        cpu_ok   = (mem_addr < BYTES);
        host_ok  = (host_addr < BYTES);
        cpu_idx  = mem_addr[AW+1:2];
        host_idx = host_addr[AW+1:2];
        host_acc = host_valid & host_ready;
    end

    assign host_ready = ~cpu_busy & rst_n;

    always_ff @(posedge clk) begin
        if (rst_n && cpu_wr && cpu_ok) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (mem_write_en[k]) begin
                    mem[cpu_idx][8*k +: 8] <= mem_write_data[8*k +: 8];
                end
            end
        end else if (host_acc && host_we && host_ok) begin
            mem[host_idx] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_data <= '0;
            host_rdata    <= '0;
            host_rvalid   <= 1'b0;
            addr_err      <= 1'b0;
        end else begin
            host_rvalid <= host_acc & ~host_we;
            if (cpu_rd) begin
                mem_read_data <= cpu_ok ? mem[cpu_idx] : '0;
            end
            if (host_acc && !host_we) begin
                host_rdata <= host_ok ? mem[host_idx] : '0;
            end
            if ((cpu_busy && !cpu_ok) || (host_acc && !host_ok)) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_dmem.sv
// Bench for mips_dmem: directed scenarios then random traffic, all checked
// against a word-array reference model.
module tb_mips_dmem;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        host_valid;
    logic        host_ready;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_rvalid;
    logic        addr_err;

    always #5 clk = ~clk;

    mips_dmem #(.DEPTH_WORDS(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .host_valid     (host_valid),
        .host_ready     (host_ready),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_rvalid    (host_rvalid),
        .addr_err       (addr_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_mrd;
    logic [31:0] exp_hrd;
    logic        exp_hrv;
    logic        exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a / 4) < DEPTH;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a / 4);
    endfunction

    task automatic model_reset();
        exp_mrd = '0;
        exp_hrd = '0;
        exp_hrv = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic step(input logic e, input logic [3:0] we, input logic rd,
                        input logic [31:0] a, wd,
                        input logic hv, hwe, input logic [31:0] ha, hwd);
        bit busy;
        en = e; mem_write_en = we; mem_read_en = rd; mem_addr = a; mem_write_data = wd;
        host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hwd;
        #1;
        busy = e && (rd || we != 4'b0);
        check("host_ready", {31'b0, host_ready}, {31'b0, !busy});
        if (e && we != 4'b0) begin
            if (in_rng(a)) begin
                for (int k = 0; k < 4; k++)
                    if (we[k]) mdl[widx(a)][8*k +: 8] = wd[8*k +: 8];
            end else exp_err = 1'b1;
        end else if (e && rd) begin
            exp_mrd = in_rng(a) ? mdl[widx(a)] : 32'h0;
            if (!in_rng(a)) exp_err = 1'b1;
        end
        exp_hrv = 1'b0;
        if (hv && !busy) begin
            if (!in_rng(ha)) exp_err = 1'b1;
            if (hwe) begin
                if (in_rng(ha)) mdl[widx(ha)] = hwd;
            end else begin
                exp_hrv = 1'b1;
                exp_hrd = in_rng(ha) ? mdl[widx(ha)] : 32'h0;
            end
        end
        @(posedge clk); #1;
        check("mem_read_data", mem_read_data, exp_mrd);
        check("host_rdata", host_rdata, exp_hrd);
        check("host_rvalid", {31'b0, host_rvalid}, {31'b0, exp_hrv});
        check("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
    endtask

    task automatic idle();
        step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mrd"},   mem_read_data, 32'h0);
        check({tag, "_hrd"},   host_rdata, 32'h0);
        check({tag, "_hrv"},   {31'b0, host_rvalid}, 32'h0);
        check({tag, "_err"},   {31'b0, addr_err}, 32'h0);
        check({tag, "_ready"}, {31'b0, host_ready}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        e, rd, hv, hwe;
        logic [3:0]  we;
        logic [31:0] a, wd, ha, hwd;

        rst_n = 1'b0;
        en = 1'b0; mem_write_en = '0; mem_read_en = 1'b0; mem_addr = '0; mem_write_data = '0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Preload and CPU read
        step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00, 32'h12345678);
        step(1'b1, 4'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("preload_read", mem_read_data, 32'hDEADBEEF);

        // Byte-lane store then host readback
        step(1'b1, 4'b0100, 1'b0, 32'h40, 32'h55555555, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        check("byte_lane_hrd", host_rdata, 32'hDE55BEEF);
        check("byte_lane_hrv", {31'b0, host_rvalid}, 32'h1);
        idle();
        check("hrv_single_pulse", {31'b0, host_rvalid}, 32'h0);

        // Arbitration: host held off while CPU reads
        repeat (3) step(1'b1, 4'b0, 1'b1, 32'h40, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1);
        step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'h1);
        step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        check("arb_word80", host_rdata, 32'h1);

        // Stall hold: en low (read request still up) while host rewrites the word
        step(1'b1, 4'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0, 1'b1, 32'h40, 32'h0, 1'b1, 1'b1, 32'h40, 32'h0);
            check("stall_hold", mem_read_data, 32'hDE55BEEF);
        end

        // Out of range: no alias onto word 0, reads return zero, flag sticky
        step(1'b1, 4'b1111, 1'b0, 32'h1000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0);
        check("oor_err_set", {31'b0, addr_err}, 32'h1);
        step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h1000, 32'h0);
        check("oor_host_rd", host_rdata, 32'h0);
        step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("oor_no_alias", host_rdata, 32'h12345678);
        repeat (3) idle();
        check("oor_err_sticky", {31'b0, addr_err}, 32'h1);

        // Read-after-write
        step(1'b1, 4'b1111, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 4'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("raw", mem_read_data, 32'hCAFEF00D);

        // Reset during a CPU write aborts it and clears the flag
        en = 1'b1; mem_write_en = 4'b1111; mem_read_en = 1'b0;
        mem_addr = 32'h10; mem_write_data = 32'h0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        en = 1'b0; mem_write_en = '0;
        model_reset();
        rst_n = 1'b1;
        step(1'b1, 4'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("reset_abort_write", mem_read_data, 32'hCAFEF00D);

        // Random traffic over a preloaded window
        for (int i = 0; i < 16; i++)
            step(1'b0, 4'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'(i * 4), $urandom);
        hv = 1'b0; hwe = 1'b0; ha = '0; hwd = '0;
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 3) != 0);
            we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            rd = $urandom_range(0, 1) == 1;
            a  = ($urandom_range(0, 40) == 0) ? ($urandom | 32'h1000)
                                              : 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            wd = $urandom;
            if (!(hv && e && (rd || we != 4'b0))) begin
                hv  = $urandom_range(0, 1) == 1;
                hwe = $urandom_range(0, 1) == 1;
                ha  = ($urandom_range(0, 40) == 0) ? ($urandom | 32'h1000)
                                                   : 32'($urandom_range(0, 15) * 4);
                hwd = $urandom;
            end
            step(e, we, rd, a, wd, hv, hwe, ha, hwd);
            if (hv && !(e && (rd || we != 4'b0))) hv = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
